// File: rtl/rvfpm_chk_pkg.sv
// rvfpm_chk_pkg: shared error codes and helpers for the rvfpm pipeline checker
package rvfpm_chk_pkg;

   localparam int ERR_CODE_W = 3;

   typedef enum logic [ERR_CODE_W-1:0] {
      NONE        = 3'd0,
      MISSING_WB  = 3'd1,
      SPURIOUS_WB = 3'd2,
      RD_MISMATCH = 3'd3,
      STALL_WB    = 3'd4,
      HAZARD      = 3'd5
   } err_code_e;

   // e[k] flags error code k; the lowest-numbered active code wins
   function automatic err_code_e first_err(input logic [5:1] e);
      return e[1] ? MISSING_WB :
             e[2] ? SPURIOUS_WB :
             e[3] ? RD_MISMATCH :
             e[4] ? STALL_WB :
             e[5] ? HAZARD : NONE;
   endfunction

endpackage

// File: rtl/rvfpm_shadow_pipe.sv
// rvfpm_shadow_pipe: shadow shift register of issued instructions with stall,
// flush, in-flight destination compare and valid-entry count
module rvfpm_shadow_pipe #(
   parameter int RW     = 5,
   parameter int STAGES = 4,
   parameter int IW     = 3
) (
   input  logic          ck,
   input  logic          rst,
   input  logic          enable,
   input  logic          flush,
   input  logic          issue_valid,
   input  logic          issue_wb,
   input  logic [RW-1:0] issue_rd,
   output logic          hazard,
   output logic          last_valid,
   output logic          last_wb,
   output logic [RW-1:0] last_rd,
   output logic [IW-1:0] inflight
);

   typedef struct packed {
      logic          valid;
      logic          wb;
      logic [RW-1:0] rd;
   } entry_t;

   entry_t [STAGES-1:0] st;
   logic                hit;
   logic [IW-1:0]       cnt;

   always_ff @(posedge ck or negedge rst) begin
      if (!rst) begin
         st <= '0;
      end else if (flush) begin
         for (int i = 0; i < STAGES; i++) st[i].valid <= 1'b0;
      end else if (enable) begin
         st[0] <= {issue_valid, issue_wb, issue_rd};
         for (int i = 1; i < STAGES; i++) st[i] <= st[i-1];
      end
   end

   // every stage takes part, including the one retiring this cycle
   always_comb begin
      hit = 1'b0;
      cnt = '0;
      for (int i = 0; i < STAGES; i++) begin
         hit = hit | (st[i].valid & st[i].wb & (st[i].rd == issue_rd));
         cnt = cnt + IW'(st[i].valid);
      end
   end

   assign hazard     = issue_valid & issue_wb & hit;
   assign last_valid = st[STAGES-1].valid;
   assign last_wb    = st[STAGES-1].wb;
   assign last_rd    = st[STAGES-1].rd;
   assign inflight   = cnt;

endmodule

// File: rtl/rvfpm_pipe_checker.sv
// rvfpm_pipe_checker: shadows the rvfpm pipeline and checks FP write-back timing
// and destination, with hazard detection, saturating error count and first-error capture
module rvfpm_pipe_checker
   import rvfpm_chk_pkg::*;
#(
   parameter int  NUM_REGS        = 32,
   parameter int  PIPELINE_STAGES = 4,
   parameter int  ERR_CNT_W       = 16,
   parameter int  HAZARD_IS_ERR   = 0,
   localparam int RW              = $clog2(NUM_REGS),
   localparam int IW              = $clog2(PIPELINE_STAGES + 1)
) (
   input  logic                  ck,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  flush,
   input  logic                  issue_valid,
   input  logic                  issue_wb,
   input  logic [RW-1:0]         issue_rd,
   input  logic                  wb_valid,
   input  logic [RW-1:0]         wb_rd,
   input  logic                  chk_en,
   input  logic                  err_clr,
   output logic                  hazard,
   output logic [IW-1:0]         inflight,
   output logic [ERR_CNT_W-1:0]  err_cnt,
   output logic                  err_flag,
   output logic [ERR_CODE_W-1:0] err_code,
   output logic [RW-1:0]         err_rd
);

   logic          last_valid;
   logic          last_wb;
   logic [RW-1:0] last_rd;
   logic          expected;
   logic [5:1]    e;
   err_code_e     code;
   logic [RW-1:0] code_rd;

   rvfpm_shadow_pipe #(
      .RW     (RW),
      .STAGES (PIPELINE_STAGES),
      .IW     (IW)
   ) u_pipe (
      .ck          (ck),
      .rst         (rst),
      .enable      (enable),
      .flush       (flush),
      .issue_valid (issue_valid),
      .issue_wb    (issue_wb),
      .issue_rd    (issue_rd),
      .hazard      (hazard),
      .last_valid  (last_valid),
      .last_wb     (last_wb),
      .last_rd     (last_rd),
      .inflight    (inflight)
   );

   assign expected = last_valid & last_wb;

   assign e = chk_en ? {hazard & enable & (HAZARD_IS_ERR != 0),
                        ~enable & wb_valid,
                        enable & expected & wb_valid & (wb_rd != last_rd),
                        enable & wb_valid & ~expected,
                        enable & expected & ~wb_valid} : '0;

   assign code    = first_err(e);
   assign code_rd = (code == SPURIOUS_WB || code == STALL_WB) ? wb_rd :
                    (code == HAZARD) ? issue_rd : last_rd;

   // an error in the clear cycle restarts the count and takes a fresh capture
   always_ff @(posedge ck or negedge rst) begin
      if (!rst) begin
         err_cnt  <= '0;
         err_flag <= 1'b0;
         err_code <= '0;
         err_rd   <= '0;
      end else if (|e) begin
         err_cnt  <= err_clr ? ERR_CNT_W'(1) : (&err_cnt ? err_cnt : err_cnt + ERR_CNT_W'(1));
         err_flag <= 1'b1;
         if (err_clr || !err_flag) begin
            err_code <= code;
            err_rd   <= code_rd;
         end
      end else if (err_clr) begin
         err_cnt  <= '0;
         err_flag <= 1'b0;
         err_code <= '0;
         err_rd   <= '0;
      end
   end

endmodule

// File: tb/tb_rvfpm_pipe_checker.sv
// tb_rvfpm_pipe_checker: directed scoreboard bench for rvfpm_pipe_checker (S=4, 4-bit counter, hazards count as errors)
module tb_rvfpm_pipe_checker;

   logic       ck = 1'b0;
   logic       rst = 1'b0;
   logic       enable, flush, issue_valid, issue_wb, wb_valid, chk_en, err_clr;
   logic [4:0] issue_rd, wb_rd;
   logic       hazard, err_flag;
   logic [2:0] inflight, err_code;
   logic [3:0] err_cnt;
   logic [4:0] err_rd;

   typedef struct packed {
      int         at;
      logic [3:0] cnt;
      logic       flag;
      logic [2:0] code;
      logic [4:0] rd;
      logic [2:0] infl;
      logic       hz;
   } exp_t;

   exp_t  q[$];
   string nq[$];
   exp_t  exp_r;
   string exp_n;
   int    cyc = 0;
   int    checks = 0;
   int    errors = 0;

   rvfpm_pipe_checker #(
      .NUM_REGS        (32),
      .PIPELINE_STAGES (4),
      .ERR_CNT_W       (4),
      .HAZARD_IS_ERR   (1)
   ) dut (
      .ck          (ck),
      .rst         (rst),
      .enable      (enable),
      .flush       (flush),
      .issue_valid (issue_valid),
      .issue_wb    (issue_wb),
      .issue_rd    (issue_rd),
      .wb_valid    (wb_valid),
      .wb_rd       (wb_rd),
      .chk_en      (chk_en),
      .err_clr     (err_clr),
      .hazard      (hazard),
      .inflight    (inflight),
      .err_cnt     (err_cnt),
      .err_flag    (err_flag),
      .err_code    (err_code),
      .err_rd      (err_rd)
   );

   always #5 ck = ~ck;
   always @(posedge ck) cyc <= cyc + 1;

   // monitor: compares every expectation queued for the current cycle
   always @(negedge ck) begin
      while (q.size() > 0 && q[0].at <= cyc) begin
         exp_r = q.pop_front();
         exp_n = nq.pop_front();
         checks++;
         if (exp_r.at != cyc ||
             {err_cnt, err_flag, err_code, err_rd, inflight, hazard} !==
             {exp_r.cnt, exp_r.flag, exp_r.code, exp_r.rd, exp_r.infl, exp_r.hz}) begin
            errors++;
            $display("FAIL %s @%0d: got cnt=%0d flag=%0d code=%0d rd=%0d inflight=%0d hazard=%0d, want cnt=%0d flag=%0d code=%0d rd=%0d inflight=%0d hazard=%0d",
                     exp_n, cyc, err_cnt, err_flag, err_code, err_rd, inflight, hazard,
                     exp_r.cnt, exp_r.flag, exp_r.code, exp_r.rd, exp_r.infl, exp_r.hz);
         end
      end
   end

   task automatic tick();
      @(posedge ck);
      #1;
   endtask

   task automatic idle();
      enable = 1; flush = 0; err_clr = 0;
      issue_valid = 0; issue_wb = 0; issue_rd = 0;
      wb_valid = 0; wb_rd = 0;
   endtask

   task automatic iss(input logic [4:0] r);
      issue_valid = 1; issue_wb = 1; issue_rd = r;
   endtask

   task automatic wb(input logic [4:0] r);
      wb_valid = 1; wb_rd = r;
   endtask

   task automatic expect_now(input string n, input logic [3:0] c, input logic f, input logic [2:0] code,
                             input logic [4:0] rd, input logic [2:0] infl, input logic hz);
      exp_t x;
      x.at = cyc; x.cnt = c; x.flag = f; x.code = code; x.rd = rd; x.infl = infl; x.hz = hz;
      q.push_back(x);
      nq.push_back(n);
   endtask

   initial begin
      idle();
      chk_en = 1;
      tick(); expect_now("reset", 0, 0, 0, 0, 0, 0);
      rst = 1;
      tick(); idle();

      // on-time write-back
      tick(); idle(); iss(5); expect_now("t1_issue", 0, 0, 0, 0, 0, 0);
      tick(); idle(); expect_now("t1_c1", 0, 0, 0, 0, 1, 0);
      tick(); idle();
      tick(); idle(); expect_now("t1_c3", 0, 0, 0, 0, 1, 0);
      tick(); idle(); wb(5); expect_now("t1_wb", 0, 0, 0, 0, 1, 0);
      tick(); idle(); expect_now("t1_done", 0, 0, 0, 0, 0, 0);

      // two stalls delay the write-back to cycle 6
      tick(); idle(); iss(5);
      tick(); idle();
      tick(); idle();
      tick(); idle(); enable = 0; expect_now("t2_stall", 0, 0, 0, 0, 1, 0);
      tick(); idle(); enable = 0;
      tick(); idle();
      tick(); idle(); wb(5); expect_now("t2_wb", 0, 0, 0, 0, 1, 0);
      tick(); idle(); expect_now("t2_done", 0, 0, 0, 0, 0, 0);

      // write-back during a stall, then the real slot goes missing
      tick(); idle(); iss(5);
      tick(); idle();
      tick(); idle();
      tick(); idle(); enable = 0;
      tick(); idle(); enable = 0; wb(5);
      tick(); idle(); expect_now("t2_stall_wb", 1, 1, 4, 5, 1, 0);
      tick(); idle();
      tick(); idle(); err_clr = 1; expect_now("t2_missing", 2, 1, 4, 5, 0, 0);
      tick(); idle(); expect_now("t2_clr", 0, 0, 0, 0, 0, 0);

      // wrong destination
      tick(); idle(); iss(7);
      tick(); idle();
      tick(); idle();
      tick(); idle();
      tick(); idle(); wb(8);
      tick(); idle(); err_clr = 1; expect_now("t3_mismatch", 1, 1, 3, 7, 0, 0);
      tick(); idle(); expect_now("t3_clr", 0, 0, 0, 0, 0, 0);

      // flush drops the in-flight entry and the same-cycle issue
      tick(); idle(); iss(3);
      tick(); idle(); flush = 1; iss(9); expect_now("t4_flush", 0, 0, 0, 0, 1, 0);
      tick(); idle(); expect_now("t4_drop", 0, 0, 0, 0, 0, 0);
      tick(); idle();
      tick(); idle();
      tick(); idle();
      tick(); idle(); expect_now("t4_nomiss", 0, 0, 0, 0, 0, 0);

      // back-to-back issue to rd=2
      tick(); idle(); iss(2);
      tick(); idle(); iss(2); expect_now("t5_hazard", 0, 0, 0, 0, 1, 1);
      tick(); idle(); expect_now("t5_haz_err", 1, 1, 5, 2, 2, 0);
      tick(); idle();
      tick(); idle(); wb(2);
      tick(); idle(); wb(2);
      tick(); idle(); err_clr = 1; expect_now("t5_retire", 1, 1, 5, 2, 0, 0);
      tick(); idle(); expect_now("t5_clr", 0, 0, 0, 0, 0, 0);

      // 2^4+3 spurious write-back cycles saturate the counter
      for (int i = 0; i < 19; i++) begin
         tick(); idle(); wb(1);
         if (i == 10) expect_now("sat_mid", 10, 1, 2, 1, 0, 0);
         if (i == 15) expect_now("sat_reach", 15, 1, 2, 1, 0, 0);
      end
      tick(); idle(); enable = 0; wb(6); err_clr = 1; expect_now("sat_hold", 15, 1, 2, 1, 0, 0);
      tick(); idle(); err_clr = 1; expect_now("clr_err_wins", 1, 1, 4, 6, 0, 0);
      tick(); idle(); expect_now("clr_final", 0, 0, 0, 0, 0, 0);

      // reset with three entries in flight and a captured error
      tick(); idle(); iss(10);
      tick(); idle(); iss(11);
      tick(); idle(); iss(12); wb(9);
      tick(); idle(); expect_now("t6_full", 1, 1, 2, 9, 3, 0);
      tick(); idle(); rst = 0; expect_now("t6_reset", 0, 0, 0, 0, 0, 0);
      tick(); idle(); rst = 1;
      for (int i = 0; i < 5; i++) begin
         tick(); idle();
      end
      expect_now("t6_quiet", 0, 0, 0, 0, 0, 0);

      tick(); tick();
      if (q.size() != 0) begin
         errors++;
         $display("FAIL pending: got %0d unchecked expectations, want 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rvfpm_pipe_checker.md
# rvfpm_pipe_checker

Synthesizable, parametrised pipeline checker that shadows the rvfpm execution pipeline. It tracks every issued instruction through a PIPELINE_STAGES-deep shadow pipeline and checks that each FP register write-back appears at the exact expected cycle with the correct destination. It also flags in-flight register hazards and keeps a saturating error count plus a first-error capture. It sits beside rvfpm in the testPr and in FPGA builds, and drives the `errorCnt*` style counters consumed by the bench.

## Interface
- NUM_REGS, 32, FP register count; RW = $clog2(NUM_REGS)
- PIPELINE_STAGES, 4, rvfpm pipeline depth (>=1)
- ERR_CNT_W, 16, error counter width
- HAZARD_IS_ERR, 0, 1 = a detected hazard also counts as an error

Ports:
- ck  in  1  clock
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- enable  in  1  pipeline advances this cycle (0 = stall)
- flush  in  1  pipeline flush
- issue_valid  in  1  instruction enters the pipeline
- issue_wb  in  1  the issued instruction writes an FP register
- issue_rd  in  RW  destination register
- wb_valid  in  1  rvfpm register-file write this cycle
- wb_rd  in  RW  register being written
- chk_en  in  1  enables checks (tracking always runs)
- err_clr  in  1  clears the error state
- hazard  out  1  combinational: issue targets an in-flight rd
- inflight  out  $clog2(PIPELINE_STAGES+1)  count of valid shadow entries
- err_cnt  out  ERR_CNT_W  saturating error count
- err_flag  out  1  sticky: at least one error seen
- err_code  out  3  code of the first error
- err_rd  out  RW  rd associated with the first error

## Operation
- Shadow entry = {valid, wb, rd}, stages 0..S-1 (S = PIPELINE_STAGES).
- Rising ck, enable=1, flush=0:
  - stage[0] <= {issue_valid, issue_wb, issue_rd}
  - stage[i] <= stage[i-1]
  - stage[S-1] retires.
- enable=0: stages hold; issue_valid is ignored and not tracked.
- flush=1: every valid bit is cleared at the edge, with priority over enable. An issue in the flush cycle is dropped.
- expected = stage[S-1].valid & stage[S-1].wb.
- Checks run only when chk_en=1. They are evaluated in the flush cycle as normal. Error codes:
  - 1 MISSING_WB: enable & expected & !wb_valid
  - 2 SPURIOUS_WB: enable & wb_valid & !expected
  - 3 RD_MISMATCH: enable & expected & wb_valid & wb_rd != stage[S-1].rd
  - 4 STALL_WB: !enable & wb_valid
  - 5 HAZARD: hazard & enable & HAZARD_IS_ERR
- hazard = issue_valid & issue_wb & (any stage with valid & wb & rd == issue_rd). All stages are included, including a retiring stage[S-1].
- Error accounting:
  - err_cnt increments by 1 per cycle with at least one error and saturates at all-ones.
  - err_flag is set with the first error.
  - err_code/err_rd capture the lowest-numbered error in the first error cycle and then hold.
  - err_rd is stage[S-1].rd for codes 1 and 3, wb_rd for codes 2 and 4, issue_rd for code 5.
- err_clr zeroes err_cnt, err_flag, err_code and err_rd. If an error occurs in the same cycle, the error wins: cnt=1 and a fresh capture.

## Timing
- Reset (async assert, sync-safe deassert): all stages invalid; err_cnt=0, err_flag=0, err_code=0, err_rd=0, inflight=0. hazard is 0 while no stage is valid.
- Issue at edge-cycle t with no stalls: write-back is expected in cycle t+S. Each stall cycle adds 1.
- S=1: write-back is expected in the cycle immediately after issue.
- Error outputs are registered and update one cycle after the offending cycle. hazard is combinational with zero latency.
- inflight is registered and reflects the stage contents after the edge.
- Reset mid-operation discards all in-flight entries. No errors are reported for them after reset.

## Structure
- Package rvfpm_chk_pkg holds:
  - err_code_e enum (NONE=0, MISSING_WB, SPURIOUS_WB, RD_MISMATCH, STALL_WB, HAZARD)
  - shadow entry struct parametrised by RW via a typedef in the module
  - ERR_CODE_W=3
- Sub-module rvfpm_shadow_pipe: shift register with stall, flush, hazard compare and popcount. The checker owns the compare and error logic.

## Test plan
- S=4, issue rd=5 at cycle 0, enable held high, wb_valid with wb_rd=5 at cycle 4 -> err_cnt stays 0, inflight is 1 during cycles 1..4, then 0.
- S=4, issue rd=5, two stall cycles after issue, wb at cycle 6 -> no error. A wb at cycle 4 instead -> err_code=4 (STALL_WB), err_rd=5, err_cnt=1.
- Issue rd=7 with wb arriving as wb_rd=8 at the expected cycle -> err_code=3, err_rd=7, err_flag=1.
- flush one cycle after issuing rd=3, no write-back -> no MISSING_WB. Issue in the flush cycle is dropped and inflight=0.
- Issue rd=2 twice, 1 cycle apart, with HAZARD_IS_ERR=1 -> hazard=1 on the second issue, err_code=5. With 2^ERR_CNT_W+3 error cycles, err_cnt saturates at all-ones.
- Assert rst low mid-flight with 3 entries -> all outputs 0 immediately. The bench drives no write-backs after reset and no errors are reported.
